trap_type_arbiter: RTL
======================

Name: trap_type_arbiter

Overview:
Parametrised trap-type generation unit for the SPARC datapath control path. It latches hardware trap requests from NUM_SRC sources plus one software trap (Ticc), and arbitrates by fixed priority. It presents the winning 8-bit tt code to the control unit with a valid/ack handshake. Traps raised while traps are disabled (ET=0) force error mode.

Parameters:
NUM_SRC, 8, number of hardware trap request lines (legal 1..32); index 0 is highest priority.
TT_WIDTH, 8, width of the tt code.
TT_BASE, 8'h01, tt code for hardware source 0; source i gets TT_BASE+i, modulo 2^TT_WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
trap_req  input  NUM_SRC  hardware trap requests, sampled every rising edge
sw_trap  input  1  software trap request (Ticc taken), sampled every rising edge
sw_operand  input  32  Ticc operand (rs1+rs2/imm result), captured with sw_trap
et  input  1  PSR.ET, enable traps
trap_ack  input  1  control unit has consumed tt_out
tt_valid  output  1  tt_out holds an unacknowledged trap
tt_out  output  TT_WIDTH  trap type of the presented trap
pending  output  NUM_SRC+1  pending vector; bit NUM_SRC is the software trap
error_mode  output  1  processor entered error mode

Behaviour:
- Reset: pending=0, sw_tt=0, tt_valid=0, tt_out=0, error_mode=0, state=IDLE. Reset overrides all other inputs on the same edge, including mid-handshake.
- Pending capture:
  - At each edge, pending[i] |= trap_req[i].
  - If sw_trap=1 and pending[NUM_SRC]=0: set pending[NUM_SRC] and capture sw_tt = {1'b1, sw_operand[TT_WIDTH-2:0]} (8'h80 + operand[6:0] at default).
  - A sw_trap while the software trap is already pending is dropped; the first sw_tt is kept.
  - Bits stay set until serviced.
- Priority: lowest set index wins. The software trap (bit NUM_SRC) has the lowest priority.
- FSM states: IDLE, PRESENT, ERROR.
- IDLE:
  - pending==0: remain in IDLE.
  - pending!=0 and et=1: latch the winner index (sel) and its tt into tt_out, set tt_valid=1, go to PRESENT.
  - pending!=0 and et=0: go to ERROR, set error_mode=1. tt_valid stays 0.
  - Arbitration uses the registered pending vector. A request sampled at edge k therefore gives tt_valid=1 after edge k+1 (2-edge latency).
- PRESENT:
  - tt_out and sel are frozen; tt_valid is held at 1.
  - A newly arriving higher-priority request does not preempt; it only sets its pending bit.
  - et is ignored in this state.
  - trap_ack=1 at an edge: clear pending[sel], tt_valid→0, go to IDLE.
  - If trap_req[sel] (or sw_trap when sel=NUM_SRC) is asserted on the ack edge, the set wins and the bit stays pending.
  - At least one IDLE cycle separates consecutive tt_valid pulses.
- tt_out holds its last value after ack until the next trap is latched.
- trap_ack in IDLE or ERROR is ignored.
- ERROR: sticky. error_mode=1 and tt_valid=0 until reset. Pending keeps accumulating and remains observable.
- Width rule: tt_out = TT_BASE + sel truncated to TT_WIDTH. Example: TT_BASE=8'hFF, sel=1 gives 8'h00.

Test Plan:
- Reset then idle: no inputs for 10 cycles -> tt_valid=0, tt_out=0, pending=0, error_mode=0.
- Single hardware trap: et=1, trap_req=8'b0000_0100 for one cycle -> tt_valid=1 two edges later with tt_out=8'h03. Hold trap_ack=0 for 5 cycles -> outputs stable. Pulse trap_ack -> tt_valid=0 and pending=0 next edge.
- Priority and no preemption: trap_req=8'b1000_0000, then trap_req[1] once tt_valid=1 -> tt_out=8'h08 stays until ack. Next trap presented is tt_out=8'h02, after one IDLE cycle.
- Software trap: et=1, sw_trap=1, sw_operand=32'h0000_0005 -> tt_out=8'h85. A second sw_trap with operand 32'h7F while pending -> ignored. A simultaneous trap_req[0] -> tt_out=8'h01 is served first, then 8'h85.
- Error mode: et=0, trap_req[3]=1 -> error_mode=1 after two edges, tt_valid never asserts. Raising et=1 -> error_mode stays 1. Reset -> error_mode=0.
- Ack/re-request collision and mid-handshake reset: assert trap_req[2] on the ack edge of a source-2 trap -> pending[2] remains 1 and tt_out=8'h03 is re-presented. Assert reset during PRESENT -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/trap_type_arbiter.sv
// Latches hardware/software trap requests and presents the fixed-priority winner's tt code.
// Latency: request edge -> tt_valid two edges later; the presented trap holds until trap_ack.
module trap_type_arbiter #(
  parameter int                  NUM_SRC  = 8,
  parameter int                  TT_WIDTH = 8,
  parameter logic [TT_WIDTH-1:0] TT_BASE  = 8'h01
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  trap_req,
  input  logic                sw_trap,
  input  logic [31:0]         sw_operand,
  input  logic                et,
  input  logic                trap_ack,
  output logic                tt_valid,
  output logic [TT_WIDTH-1:0] tt_out,
  output logic [NUM_SRC:0]    pending,
  output logic                error_mode
);

  localparam int SELW = $clog2(NUM_SRC + 1);

  typedef enum logic [1:0] {IDLE, PRESENT, ERROR} state_t;

  state_t              state, state_nxt;
  logic [NUM_SRC:0]    pend_q, pend_nxt, clr, set_vec;
  logic [TT_WIDTH-1:0] sw_tt_q, tt_q, hw_tt;
  logic [SELW-1:0]     sel_q, win_idx;
  logic                latch_win, ack_take, sw_accept;
  logic                unused_operand_bits;

  assign unused_operand_bits = ^sw_operand[31:TT_WIDTH-1];

  // Lowest set index wins; the software bit sits at the top, so it loses to all hardware sources.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC; i >= 0; i--) begin
      if (pend_q[i]) win_idx = SELW'(i);
    end
  end

  assign hw_tt = TT_BASE + TT_WIDTH'(win_idx);

  always_comb begin
    state_nxt = state;
    latch_win = 1'b0;
    ack_take  = 1'b0;
    case (state)
      IDLE: begin
        if (|pend_q) begin
          if (et) begin
            state_nxt = PRESENT;
            latch_win = 1'b1;
          end else begin
            state_nxt = ERROR;
          end
        end
      end
      PRESENT: begin
        if (trap_ack) begin
          state_nxt = IDLE;
          ack_take  = 1'b1;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i <= NUM_SRC; i++) begin
      clr[i] = ack_take && (sel_q == SELW'(i));
    end
  end

  // A new request on the ack edge of the same source re-arms the bit (set beats clear).
  assign sw_accept = sw_trap && (!pend_q[NUM_SRC] || clr[NUM_SRC]);
  assign set_vec   = {sw_accept, trap_req};
  assign pend_nxt  = (pend_q & ~clr) | set_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pend_q  <= '0;
      sw_tt_q <= '0;
      tt_q    <= '0;
      sel_q   <= '0;
    end else begin
      state  <= state_nxt;
      pend_q <= pend_nxt;
      if (sw_accept) sw_tt_q <= {1'b1, sw_operand[TT_WIDTH-2:0]};
      if (latch_win) begin
        sel_q <= win_idx;
        tt_q  <= (win_idx == SELW'(NUM_SRC)) ? sw_tt_q : hw_tt;
      end
    end
  end

  assign tt_valid   = (state == PRESENT);
  assign error_mode = (state == ERROR);
  assign tt_out     = tt_q;
  assign pending    = pend_q;

endmodule
